// File: rtl/axi_rd_stream.sv
// AXI4 read master that drains a fixed-stride ring buffer onto an AXI-Stream port.
// Single-beat reads, one outstanding; publishes rd_ptr so the writer can detect a full ring.
module axi_rd_stream #(
    parameter int unsigned DATA_WIDTH   = 512,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH   = 34,
    parameter int unsigned ID_WIDTH     = 6,
    parameter int unsigned RING_ENTRIES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [ADDR_WIDTH-1:0]   axi_base_addr,
    input  logic                    axi_base_addr_valid,
    input  logic [31:0]             wr_ptr,
    output logic [31:0]             rd_ptr,
    output logic                    rd_err,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready
);

    localparam int unsigned OFFSET_W = $clog2(KEEP_WIDTH);
    localparam logic [31:0] LAST_IDX = 32'(RING_ENTRIES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_ADDR = 2'd1;
    localparam logic [1:0] ST_RD_DATA = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [31:0]           rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH-1:0] base_q,      base_d;
    logic                  pend_q,      pend_d;
    logic [ADDR_WIDTH-1:0] pend_base_q, pend_base_d;
    logic [ID_WIDTH-1:0]   arid_q,      arid_d;
    logic [ADDR_WIDTH-1:0] araddr_q,    araddr_d;
    logic                  arvalid_q,   arvalid_d;
    logic                  last_flag_q, last_flag_d;
    logic [DATA_WIDTH-1:0] tdata_q,     tdata_d;
    logic                  tvalid_q,    tvalid_d;
    logic                  tlast_q,     tlast_d;
    logic                  rd_err_q,    rd_err_d;

    logic                  empty_c;
    logic [31:0]           rd_ptr_next_c;
    logic [ADDR_WIDTH-1:0] ar_addr_c;
    logic                  rready_c;
    logic                  r_hs_c;

    // rid/rlast carry no information with a single outstanding single-beat read
    logic unused_ok;
    assign unused_ok = ^{m_axi_rid, m_axi_rlast};

    assign empty_c       = (rd_ptr_q == wr_ptr);
    assign rd_ptr_next_c = (rd_ptr_q == LAST_IDX) ? 32'd0 : rd_ptr_q + 32'd1;
    assign ar_addr_c     = base_q + (ADDR_WIDTH'(rd_ptr_q) << OFFSET_W);
    assign rready_c      = (state_q == ST_RD_DATA) && (!tvalid_q || m_axis_tready);
    assign r_hs_c        = m_axi_rvalid && rready_c;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        base_d      = base_q;
        pend_d      = pend_q;
        pend_base_d = pend_base_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        last_flag_d = last_flag_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        rd_err_d    = rd_err_q;

        if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        // A base load arriving mid-transaction waits until the FSM is back in IDLE
        if (axi_base_addr_valid && (state_q != ST_IDLE)) begin
            pend_d      = 1'b1;
            pend_base_d = axi_base_addr;
        end

        case (state_q)
            ST_IDLE: begin
                if (axi_base_addr_valid) begin
                    base_d   = axi_base_addr;
                    rd_ptr_d = 32'd0;
                    pend_d   = 1'b0;
                end else if (pend_q) begin
                    base_d   = pend_base_q;
                    rd_ptr_d = 32'd0;
                    pend_d   = 1'b0;
                end else if (enable && !empty_c) begin
                    state_d     = ST_RD_ADDR;
                    arvalid_d   = 1'b1;
                    araddr_d    = ar_addr_c;
                    last_flag_d = (rd_ptr_next_c == wr_ptr);
                end
            end
            ST_RD_ADDR: begin
                if (m_axi_arready) begin
                    arvalid_d = 1'b0;
                    arid_d    = arid_q + ID_WIDTH'(1);
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs_c) begin
                    tdata_d  = m_axi_rdata;
                    tvalid_d = 1'b1;
                    tlast_d  = last_flag_q;
                    rd_err_d = rd_err_q | (m_axi_rresp != 2'b00);
                    rd_ptr_d = rd_ptr_next_c;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            base_q      <= '0;
            pend_q      <= 1'b0;
            pend_base_q <= '0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            last_flag_q <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            rd_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            base_q      <= base_d;
            pend_q      <= pend_d;
            pend_base_q <= pend_base_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            last_flag_q <= last_flag_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            rd_err_q    <= rd_err_d;
        end
    end

    // Stream payload is qualified by tvalid, so it needs no reset
    always_ff @(posedge clk) begin
        tdata_q <= tdata_d;
    end

    assign rd_ptr        = rd_ptr_q;
    assign rd_err        = rd_err_q;
    assign m_axi_arid    = arid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'(OFFSET_W);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_c;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = '1;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axi_rd_stream.sv
// Bench for axi_rd_stream: AXI read slave model plus AR/stream scoreboards.
module tb_axi_rd_stream;

    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned AW = 34;
    localparam int unsigned IW = 6;
    localparam int unsigned RE = 4;
    localparam logic [AW-1:0] BASE1 = 34'h1_0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] axi_base_addr;
    logic          axi_base_addr_valid;
    logic [31:0]   wr_ptr;
    logic [31:0]   rd_ptr;
    logic          rd_err;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid;
    logic          m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast;
    logic          m_axi_rvalid;
    logic          m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;

    axi_rd_stream #(
        .DATA_WIDTH  (DW),
        .KEEP_WIDTH  (KW),
        .ADDR_WIDTH  (AW),
        .ID_WIDTH    (IW),
        .RING_ENTRIES(RE)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .axi_base_addr      (axi_base_addr),
        .axi_base_addr_valid(axi_base_addr_valid),
        .wr_ptr             (wr_ptr),
        .rd_ptr             (rd_ptr),
        .rd_err             (rd_err),
        .m_axi_arid         (m_axi_arid),
        .m_axi_araddr       (m_axi_araddr),
        .m_axi_arlen        (m_axi_arlen),
        .m_axi_arsize       (m_axi_arsize),
        .m_axi_arburst      (m_axi_arburst),
        .m_axi_arlock       (m_axi_arlock),
        .m_axi_arcache      (m_axi_arcache),
        .m_axi_arprot       (m_axi_arprot),
        .m_axi_arvalid      (m_axi_arvalid),
        .m_axi_arready      (m_axi_arready),
        .m_axi_rid          (m_axi_rid),
        .m_axi_rdata        (m_axi_rdata),
        .m_axi_rresp        (m_axi_rresp),
        .m_axi_rlast        (m_axi_rlast),
        .m_axi_rvalid       (m_axi_rvalid),
        .m_axi_rready       (m_axi_rready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tkeep       (m_axis_tkeep),
        .m_axis_tlast       (m_axis_tlast),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Slave knobs
    int        ar_delay   = 0;
    int        r_delay    = 0;
    logic [1:0] rresp_cfg = 2'b00;
    bit        tready_low = 1'b0;
    int        n_ar       = 0;

    // Scoreboard queues
    logic [AW-1:0] exp_addr_q[$];
    logic [IW-1:0] exp_id_q[$];
    logic [DW-1:0] exp_data_q[$];
    logic          exp_last_q[$];

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
        logic [63:0] w;
        w = 64'(a) ^ 64'hDEAD_BEEF_0000_0000;
        return {8{w}};
    endfunction

    task automatic push_read(input logic [AW-1:0] a, input int id, input logic last);
        exp_addr_q.push_back(a);
        exp_id_q.push_back(IW'(id));
        exp_data_q.push_back(beat_data(a));
        exp_last_q.push_back(last);
    endtask

    task automatic load_base(input logic [AW-1:0] a);
        @(negedge clk);
        axi_base_addr       = a;
        axi_base_addr_valid = 1'b1;
        @(negedge clk);
        axi_base_addr_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (exp_addr_q.size() == 0 && exp_data_q.size() == 0 && !m_axis_tvalid) break;
        end
        repeat (3) @(negedge clk);
        #2;
        check_eq("drain_left", DW'(exp_addr_q.size() + exp_data_q.size()), DW'(0));
    endtask

    // AXI read slave, AR/stream monitors and stability checks
    initial begin : axi_slave
        logic [AW-1:0] r_addr;
        int            r_cnt;
        int            ar_cnt;
        bit            r_pend;
        bit            ar_hs, r_hs, s_hs;
        bit            ar_wait, s_wait;
        logic [AW-1:0] prev_addr;
        logic [IW-1:0] prev_id;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        r_addr = '0; r_cnt = 0; ar_cnt = 0; r_pend = 1'b0;
        ar_hs = 1'b0; r_hs = 1'b0; s_hs = 1'b0; ar_wait = 1'b0; s_wait = 1'b0;
        prev_addr = '0; prev_id = '0; prev_data = '0; prev_last = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axi_rid = '0; m_axi_rlast = 1'b1; m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            if (r_hs || !rst_n) m_axi_rvalid = 1'b0;
            if (!rst_n) r_pend = 1'b0;
            if (r_pend && !m_axi_rvalid) begin
                if (r_cnt == 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = beat_data(r_addr);
                    m_axi_rresp  = rresp_cfg;
                    r_pend       = 1'b0;
                end else begin
                    r_cnt--;
                end
            end
            if (m_axi_arvalid) begin
                m_axi_arready = (ar_cnt >= ar_delay);
                ar_cnt++;
            end else begin
                m_axi_arready = 1'b0;
                ar_cnt        = 0;
            end
            m_axis_tready = !tready_low;
            #1;
            ar_hs = m_axi_arvalid && m_axi_arready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            s_hs  = m_axis_tvalid && m_axis_tready;

            if (m_axi_arvalid && ar_wait) begin
                check_eq("araddr_stable", DW'(m_axi_araddr), DW'(prev_addr));
                check_eq("arid_stable", DW'(m_axi_arid), DW'(prev_id));
            end
            ar_wait   = m_axi_arvalid && !ar_hs;
            prev_addr = m_axi_araddr;
            prev_id   = m_axi_arid;

            if (m_axis_tvalid && s_wait) begin
                check_eq("tdata_stable", m_axis_tdata, prev_data);
                check_eq("tlast_stable", DW'(m_axis_tlast), DW'(prev_last));
            end
            s_wait    = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;

            if (ar_hs) begin
                n_ar++;
                r_pend = 1'b1;
                r_addr = m_axi_araddr;
                r_cnt  = r_delay;
                if (exp_addr_q.size() == 0) begin
                    check_eq("ar_unexpected", DW'(exp_addr_q.size()), DW'(1));
                end else begin
                    check_eq("araddr", DW'(m_axi_araddr), DW'(exp_addr_q.pop_front()));
                    check_eq("arid", DW'(m_axi_arid), DW'(exp_id_q.pop_front()));
                end
            end

            if (s_hs) begin
                if (exp_data_q.size() == 0) begin
                    check_eq("beat_unexpected", DW'(exp_data_q.size()), DW'(1));
                end else begin
                    check_eq("tdata", m_axis_tdata, exp_data_q.pop_front());
                    check_eq("tlast", DW'(m_axis_tlast), DW'(exp_last_q.pop_front()));
                    check_eq("tkeep", DW'(m_axis_tkeep), DW'({KW{1'b1}}));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n0;
        rst_n = 1'b0; enable = 1'b0; axi_base_addr = '0; axi_base_addr_valid = 1'b0; wr_ptr = 32'd0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_arvalid", DW'(m_axi_arvalid), DW'(0));
        check_eq("rst_rready", DW'(m_axi_rready), DW'(0));
        check_eq("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
        check_eq("rst_tlast", DW'(m_axis_tlast), DW'(0));
        check_eq("rst_rd_err", DW'(rd_err), DW'(0));
        check_eq("rst_rd_ptr", DW'(rd_ptr), DW'(0));
        check_eq("rst_araddr", DW'(m_axi_araddr), DW'(0));
        check_eq("rst_arid", DW'(m_axi_arid), DW'(0));
        check_eq("arlen", DW'(m_axi_arlen), DW'(0));
        check_eq("arsize", DW'(m_axi_arsize), DW'(6));
        check_eq("arburst", DW'(m_axi_arburst), DW'(1));
        check_eq("arlock_cache_prot", DW'({m_axi_arlock, m_axi_arcache, m_axi_arprot}), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // T1: two entries from base 0x1_0000_0000
        load_base(BASE1);
        push_read(BASE1,         0, 1'b0);
        push_read(BASE1 + 'h40,  1, 1'b1);
        enable = 1'b1;
        wr_ptr = 32'd2;
        wait_drain(200);
        check_eq("t1_rd_ptr", DW'(rd_ptr), DW'(2));
        check_eq("t1_rd_err", DW'(rd_err), DW'(0));

        // T2: advance to entry 3, then wrap through 0
        push_read(BASE1 + 'h80, 2, 1'b1);
        wr_ptr = 32'd3;
        wait_drain(200);
        check_eq("t2_rd_ptr3", DW'(rd_ptr), DW'(3));
        push_read(BASE1 + 'hC0, 3, 1'b0);
        push_read(BASE1,        4, 1'b1);
        wr_ptr = 32'd1;
        wait_drain(200);
        check_eq("t2_rd_ptr_wrap", DW'(rd_ptr), DW'(1));

        // T3: stream back-pressure with a read beat waiting
        tready_low = 1'b1;
        push_read(BASE1 + 'h40, 5, 1'b0);
        push_read(BASE1 + 'h80, 6, 1'b1);
        wr_ptr = 32'd3;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            check_eq("t3_rready", DW'(m_axi_rready), DW'(0));
            check_eq("t3_tvalid", DW'(m_axis_tvalid), DW'(1));
            check_eq("t3_tdata", m_axis_tdata, exp_data_q[0]);
            check_eq("t3_arvalid", DW'(m_axi_arvalid), DW'(0));
        end
        tready_low = 1'b0;
        wait_drain(200);
        check_eq("t3_rd_ptr", DW'(rd_ptr), DW'(3));

        // T4: slow arready and an error response
        ar_delay  = 5;
        rresp_cfg = 2'b10;
        push_read(BASE1 + 'hC0, 7, 1'b1);
        wr_ptr = 32'd0;
        wait_drain(200);
        check_eq("t4_rd_err_set", DW'(rd_err), DW'(1));
        ar_delay  = 0;
        rresp_cfg = 2'b00;
        push_read(BASE1, 8, 1'b1);
        wr_ptr = 32'd1;
        wait_drain(200);
        check_eq("t4_rd_err_sticky", DW'(rd_err), DW'(1));
        check_eq("t4_rd_ptr", DW'(rd_ptr), DW'(1));

        // T5: base load while a beat is in flight
        r_delay = 4;
        push_read(BASE1 + 'h40, 9,  1'b1);
        push_read(34'h2000,     10, 1'b0);
        push_read(34'h2040,     11, 1'b1);
        n0 = n_ar;
        wr_ptr = 32'd2;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (n_ar != n0) break;
        end
        check_eq("t5_ar_seen", DW'(n_ar != n0), DW'(1));
        r_delay = 0;
        @(negedge clk);
        axi_base_addr       = 34'h2000;
        axi_base_addr_valid = 1'b1;
        @(negedge clk);
        axi_base_addr_valid = 1'b0;
        wait_drain(200);
        check_eq("t5_rd_ptr", DW'(rd_ptr), DW'(2));

        // T6: reset while an AR is stalled
        ar_delay = 1000;
        wr_ptr   = 32'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (m_axi_arvalid) break;
        end
        check_eq("t6_arvalid_before", DW'(m_axi_arvalid), DW'(1));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #2;
        check_eq("t6_arvalid", DW'(m_axi_arvalid), DW'(0));
        check_eq("t6_tvalid", DW'(m_axis_tvalid), DW'(0));
        check_eq("t6_rd_ptr", DW'(rd_ptr), DW'(0));
        check_eq("t6_rd_err", DW'(rd_err), DW'(0));
        check_eq("t6_rready", DW'(m_axi_rready), DW'(0));
        check_eq("t6_arid", DW'(m_axi_arid), DW'(0));
        enable   = 1'b0;
        wr_ptr   = 32'd0;
        ar_delay = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset: arid restarts at 0
        load_base(34'h3000);
        push_read(34'h3000, 0, 1'b1);
        enable = 1'b1;
        wr_ptr = 32'd1;
        wait_drain(200);
        check_eq("post_rst_rd_ptr", DW'(rd_ptr), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
